// File: rtl/acc24_frame_ctrl.sv
// Frame accumulator around an external 24-bit adder: 2-stage operand pipeline, saturating counts.
// Optional sticky sx check is built only when SX_CHECK_EN is defined.
module acc24_frame_ctrl #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [23:0]      in_data_i,
  input  logic             in_sub_i,
  input  logic             in_last_i,
  output logic [23:0]      add_a_o,
  output logic [23:0]      add_b_o,
  output logic             add_c0_o,
  input  logic [23:0]      add_s_i,
  input  logic             add_c24_i,
  input  logic             add_sx_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [23:0]      out_sum_o,
  output logic [CNT_W-1:0] out_len_o,
  output logic [CNT_W-1:0] out_ovf_o,
  output logic             sx_err_o
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q;
  logic [23:0]      acc_q;
  logic [23:0]      op_q;
  logic             sub_q;
  logic             last_q;
  logic             op_v_q;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic             out_valid_q;
  logic             accept;
  logic             ovf_event;
  logic             frame_clr;

  assign in_ready_o = (state_q == StIdle) || (state_q == StRun);
  assign accept     = in_valid_i && in_ready_o;
  // Carry-out on add, missing carry (borrow) on subtract.
  assign ovf_event  = add_c24_i ^ sub_q;
  assign frame_clr  = (state_q == StDone) && out_ready_i;

  assign add_a_o  = acc_q;
  assign add_b_o  = op_q ^ {24{sub_q}};
  assign add_c0_o = sub_q;

  always_comb begin
    len_d = len_q;
    ovf_d = ovf_q;
    if (op_v_q) begin
      if (len_q != CntMax) len_d = len_q + CntOne;
      if (ovf_event && (ovf_q != CntMax)) ovf_d = ovf_q + CntOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      op_q        <= '0;
      sub_q       <= 1'b0;
      last_q      <= 1'b0;
      op_v_q      <= 1'b0;
      len_q       <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      op_v_q <= accept;
      if (accept) begin
        op_q   <= in_data_i;
        sub_q  <= in_sub_i;
        last_q <= in_last_i;
      end
      if (op_v_q) acc_q <= add_s_i;
      len_q <= len_d;
      ovf_q <= ovf_d;

      unique case (state_q)
        StIdle: begin
          if (accept) state_q <= in_last_i ? StDrain : StRun;
        end
        StRun: begin
          if (accept && in_last_i) state_q <= StDrain;
        end
        StDrain: begin
          if (op_v_q && last_q) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            len_q       <= '0;
            ovf_q       <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_sum_o   = acc_q;
  assign out_len_o   = len_q;
  assign out_ovf_o   = ovf_q;

`ifdef SX_CHECK_EN
  logic sx_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || frame_clr) begin
      sx_err_q <= 1'b0;
    end else if (op_v_q && add_sx_i) begin
      sx_err_q <= 1'b1;
    end
  end

  assign sx_err_o = sx_err_q;
`else
  logic unused_sx;
  logic unused_clr;

  assign unused_sx  = add_sx_i;
  assign unused_clr = frame_clr;
  assign sx_err_o   = 1'b0;
`endif

endmodule
